// File: rtl/seven_seg_scan_driver_if.sv
// Bundle of the control/data inputs and multiplexed display outputs of the
// seven-segment scan driver; the master side feeds data, the slave side drives the display.
interface seven_seg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    enable;
  logic                    load;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [6:0]              segs;
  logic                    dp_n;
  logic [NUM_DIGITS-1:0]   an_n;
  logic                    frame_done;

  modport master (
    output enable, load, value, dp_in,
    input  segs, dp_n, an_n, frame_done
  );

  modport slave (
    input  enable, load, value, dp_in,
    output segs, dp_n, an_n, frame_done
  );
endinterface

// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed seven-segment driver: a shadowed hex value is scanned one
// digit per slot, with anode guard time and optional leading-zero blanking.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS    = 4,
  parameter int DIV           = 50000,
  parameter int GUARD         = 2,
  parameter int BLANK_LEADING = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  seven_seg_scan_driver_if.slave bus_io
);
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [1:0]              rstSync_q;
  logic                    active;
  logic [CNT_W-1:0]        slotCnt_q, slotCnt_d;
  logic [IDX_W-1:0]        digitIdx_q, digitIdx_d;
  logic [4*NUM_DIGITS-1:0] shadowVal_q, slotVal_q, slotVal_d;
  logic [NUM_DIGITS-1:0]   shadowDp_q, slotDp_q, slotDp_d;
  logic                    slotEnd, frameEnd;
  logic [NUM_DIGITS-1:0]   blankMask;
  logic                    allZero;
  logic [3:0]              curNibble;
  logic                    curDp, curBlank, inGuard;
  logic [6:0]              segs_q, segs_d;
  logic                    dpN_q, dpN_d;
  logic [NUM_DIGITS-1:0]   anN_q, anN_d;
  logic                    frameDone_q, frameDone_d;

  function automatic logic [6:0] decodeHex(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  // Reset asserts immediately but releases on clk, so the first slot is always complete.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rstSync_q <= '0;
    else        rstSync_q <= {rstSync_q[0], 1'b1};
  end

  assign active   = bus_io.enable & rstSync_q[1];
  assign slotEnd  = active && (slotCnt_q == CNT_LAST);
  assign frameEnd = slotEnd && (digitIdx_q == IDX_LAST);

  // The per-slot copy only refreshes at a slot boundary, so one slot never mixes old and new data.
  always_comb begin
    slotCnt_d  = slotCnt_q + CNT_W'(1);
    digitIdx_d = digitIdx_q;
    slotVal_d  = slotVal_q;
    slotDp_d   = slotDp_q;
    if (!active) begin
      slotCnt_d  = '0;
      digitIdx_d = '0;
    end else if (slotEnd) begin
      slotCnt_d  = '0;
      digitIdx_d = frameEnd ? '0 : digitIdx_q + IDX_W'(1);
    end
    if (!active || slotEnd) begin
      slotVal_d = bus_io.load ? bus_io.value : shadowVal_q;
      slotDp_d  = bus_io.load ? bus_io.dp_in : shadowDp_q;
    end
  end

  always_comb begin
    allZero   = 1'b1;
    blankMask = '0;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      allZero      = allZero & (slotVal_q[4*k +: 4] == 4'h0);
      blankMask[k] = allZero && (BLANK_LEADING != 0) && (k != 0);
    end
  end

  always_comb begin
    curNibble = '0;
    curDp     = 1'b0;
    curBlank  = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digitIdx_q == IDX_W'(k)) begin
        curNibble = slotVal_q[4*k +: 4];
        curDp     = slotDp_q[k];
        curBlank  = blankMask[k];
      end
    end
    inGuard = (GUARD > 0) && (int'(slotCnt_q) < GUARD);
  end

  always_comb begin
    segs_d      = 7'h7F;
    dpN_d       = 1'b1;
    anN_d       = '1;
    frameDone_d = frameEnd;
    if (active) begin
      segs_d = curBlank ? 7'h7F : decodeHex(curNibble);
      dpN_d  = ~curDp;
      for (int k = 0; k < NUM_DIGITS; k++) begin
        anN_d[k] = !((digitIdx_q == IDX_W'(k)) && !inGuard);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotCnt_q   <= '0;
      digitIdx_q  <= '0;
      shadowVal_q <= '0;
      shadowDp_q  <= '0;
      slotVal_q   <= '0;
      slotDp_q    <= '0;
      segs_q      <= 7'h7F;
      dpN_q       <= 1'b1;
      anN_q       <= '1;
      frameDone_q <= 1'b0;
    end else begin
      slotCnt_q   <= slotCnt_d;
      digitIdx_q  <= digitIdx_d;
      slotVal_q   <= slotVal_d;
      slotDp_q    <= slotDp_d;
      segs_q      <= segs_d;
      dpN_q       <= dpN_d;
      anN_q       <= anN_d;
      frameDone_q <= frameDone_d;
      if (bus_io.load) begin
        shadowVal_q <= bus_io.value;
        shadowDp_q  <= bus_io.dp_in;
      end
    end
  end

  assign bus_io.segs       = segs_q;
  assign bus_io.dp_n       = dpN_q;
  assign bus_io.an_n       = anN_q;
  assign bus_io.frame_done = frameDone_q;
endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// Directed bench for the scan driver with NUM_DIGITS=4, DIV=4, GUARD=1:
// a digit table for full frames plus hand-written load, reset and enable sequences.
module tb_seven_seg_scan_driver;
  localparam int NUM_DIGITS = 4;
  localparam int DIV        = 4;
  localparam int GUARD      = 1;

  typedef struct {
    logic [15:0] value;
    logic [3:0]  dp;
    logic [6:0]  segs;
    logic        dpN;
  } digitVec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  digitVec_t vecs [16];

  seven_seg_scan_driver_if #(.NUM_DIGITS(NUM_DIGITS)) busIf ();

  seven_seg_scan_driver #(
    .NUM_DIGITS(NUM_DIGITS),
    .DIV(DIV),
    .GUARD(GUARD),
    .BLANK_LEADING(1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus_io(busIf)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic ld, input logic [15:0] val, input logic [3:0] dp);
    busIf.enable = en;
    busIf.load   = ld;
    busIf.value  = val;
    busIf.dp_in  = dp;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] expAn, input logic [6:0] expSegs,
                             input logic expDpN, input logic expFrame);
    checks++;
    if ({busIf.an_n, busIf.segs, busIf.dp_n, busIf.frame_done} !== {expAn, expSegs, expDpN, expFrame}) begin
      errors++;
      $display("[TB] FAIL %s: got an_n=%b segs=%b dp_n=%b frame_done=%b, expected an_n=%b segs=%b dp_n=%b frame_done=%b",
               name, busIf.an_n, busIf.segs, busIf.dp_n, busIf.frame_done, expAn, expSegs, expDpN, expFrame);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0] oneHot;
    logic [3:0] expAn;
    logic       seen;

    vecs[0]  = '{16'h12AF, 4'b0000, 7'b0001110, 1'b1};
    vecs[1]  = '{16'h12AF, 4'b0000, 7'b0001000, 1'b1};
    vecs[2]  = '{16'h12AF, 4'b0000, 7'b0100100, 1'b1};
    vecs[3]  = '{16'h12AF, 4'b0000, 7'b1111001, 1'b1};
    vecs[4]  = '{16'h0007, 4'b0100, 7'b1111000, 1'b1};
    vecs[5]  = '{16'h0007, 4'b0100, 7'b1111111, 1'b1};
    vecs[6]  = '{16'h0007, 4'b0100, 7'b1111111, 1'b0};
    vecs[7]  = '{16'h0007, 4'b0100, 7'b1111111, 1'b1};
    vecs[8]  = '{16'h0000, 4'b0000, 7'b1000000, 1'b1};
    vecs[9]  = '{16'h0000, 4'b0000, 7'b1111111, 1'b1};
    vecs[10] = '{16'h0000, 4'b0000, 7'b1111111, 1'b1};
    vecs[11] = '{16'h0000, 4'b0000, 7'b1111111, 1'b1};
    vecs[12] = '{16'h0305, 4'b0001, 7'b0010010, 1'b0};
    vecs[13] = '{16'h0305, 4'b0001, 7'b1000000, 1'b1};
    vecs[14] = '{16'h0305, 4'b0001, 7'b0110000, 1'b1};
    vecs[15] = '{16'h0305, 4'b0001, 7'b1111111, 1'b1};

    applyStimulus(1'b0, 1'b0, 16'h0000, 4'h0);
    #2 rst_n = 1'b0;
    #1 checkOutput("reset async", 4'hF, 7'h7F, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1 checkOutput("reset held", 4'hF, 7'h7F, 1'b1, 1'b0);
    #3 rst_n = 1'b1;
    repeat (4) tick();
    checkOutput("idle disabled", 4'hF, 7'h7F, 1'b1, 1'b0);

    // Each scenario: load while disabled, scramble value without load, then one full frame.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b0, 1'b1, vecs[4*s].value, vecs[4*s].dp);
      tick();
      applyStimulus(1'b0, 1'b0, 16'hFFFF, 4'hF);
      tick();
      checkOutput("disabled after load", 4'hF, 7'h7F, 1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0, 16'hFFFF, 4'hF);
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 4; c++) begin
          tick();
          oneHot = 4'b0001 << d;
          expAn  = (c < GUARD) ? 4'hF : ~oneHot;
          checkOutput($sformatf("scan v=%h digit%0d cyc%0d", vecs[4*s].value, d, c),
                      expAn, vecs[4*s+d].segs, vecs[4*s+d].dpN, (d == 3) && (c == 3));
        end
      end
      applyStimulus(1'b0, 1'b0, 16'hFFFF, 4'hF);
      tick();
      checkOutput("disable after frame", 4'hF, 7'h7F, 1'b1, 1'b0);
    end

    // Load coinciding with a slot change, then a mid-slot load and a value change without load.
    applyStimulus(1'b0, 1'b1, 16'h1111, 4'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 16'h1111, 4'h0);
    tick(); checkOutput("old d0 c0", 4'hF, 7'b1111001, 1'b1, 1'b0);
    tick(); checkOutput("old d0 c1", 4'hE, 7'b1111001, 1'b1, 1'b0);
    tick(); checkOutput("old d0 c2", 4'hE, 7'b1111001, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h2222, 4'h0);
    tick(); checkOutput("old d0 c3 at load", 4'hE, 7'b1111001, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h2222, 4'h0);
    tick(); checkOutput("new d1 c0", 4'hF, 7'b0100100, 1'b1, 1'b0);
    tick(); checkOutput("new d1 c1", 4'hD, 7'b0100100, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h3333, 4'h0);
    tick(); checkOutput("midslot load held", 4'hD, 7'b0100100, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h8888, 4'h0);
    tick(); checkOutput("midslot load held c3", 4'hD, 7'b0100100, 1'b1, 1'b0);
    tick(); checkOutput("mid load d2 c0", 4'hF, 7'b0110000, 1'b1, 1'b0);
    tick(); checkOutput("mid load d2 c1", 4'hB, 7'b0110000, 1'b1, 1'b0);

    // Short reset pulse while digit 2 is lit.
    #1 rst_n = 1'b0;
    #1 checkOutput("midslot reset async", 4'hF, 7'h7F, 1'b1, 1'b0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (busIf.an_n !== 4'hF) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("[TB] FAIL restart timeout: got an_n=%b for 10 cycles, expected a digit to light", busIf.an_n);
    end
    checkOutput("restart first lit", 4'hE, 7'b1000000, 1'b1, 1'b0);
    tick(); checkOutput("restart d0 c2", 4'hE, 7'b1000000, 1'b1, 1'b0);
    tick(); checkOutput("restart d0 c3", 4'hE, 7'b1000000, 1'b1, 1'b0);
    tick(); checkOutput("restart d1 guard", 4'hF, 7'h7F, 1'b1, 1'b0);
    tick(); checkOutput("restart d1 c1", 4'hD, 7'h7F, 1'b1, 1'b0);

    // Enable dropped mid-scan, load while disabled, then resume from digit 0.
    applyStimulus(1'b0, 1'b0, 16'h8888, 4'h0);
    tick(); checkOutput("enable drop", 4'hF, 7'h7F, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 16'h0042, 4'h0);
    tick(); checkOutput("disabled load", 4'hF, 7'h7F, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h0000, 4'h0);
    tick(); checkOutput("resume d0 c0", 4'hF, 7'b0100100, 1'b1, 1'b0);
    tick(); checkOutput("resume d0 c1", 4'hE, 7'b0100100, 1'b1, 1'b0);
    tick(); checkOutput("resume d0 c2", 4'hE, 7'b0100100, 1'b1, 1'b0);
    tick(); checkOutput("resume d0 c3", 4'hE, 7'b0100100, 1'b1, 1'b0);
    tick(); checkOutput("resume d1 c0", 4'hF, 7'b0011001, 1'b1, 1'b0);
    tick(); checkOutput("resume d1 c1", 4'hD, 7'b0011001, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
